// File: rtl/rv32i_pkg.sv
// rv32i_pkg: format codes, opcodes and loader state encoding
// shared by the RV32I program loader and its instruction encoder.
package rv32i_pkg;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_J = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_R = 3'd5;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_VERIFY
  } ld_state_e;

  // True when v[31:msb] are all equal, i.e. v fits as a signed field.
  function automatic logic sext_ok(
    input logic [31:0] v,
    input int unsigned msb
  );
    logic [31:0] m;
    m = 32'hFFFF_FFFF << msb;
    return ((v & m) == m) || ((v & m) == 32'h0);
  endfunction

endpackage

// File: rtl/rv32i_program_loader_if.sv
// rv32i_program_loader_if: instruction-field request channel
// with valid/ready handshake; master drives requests, slave is the loader.
interface rv32i_program_loader_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_last;
  logic [2:0]  fmt;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  modport master (
    output req_valid, req_last, fmt, op, funct3,
    output funct7b5, rd, rs1, rs2, imm,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_last, fmt, op, funct3,
    input  funct7b5, rd, rs1, rs2, imm,
    output req_ready
  );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: packs RV32I fields into a 32-bit word and
// flags immediates that do not fit the selected format.
module rv32i_instr_encoder
  import rv32i_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  op_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_o
);

  logic is_shift;
  assign is_shift = (op_i == OP_ITYPE)
                 && (funct3_i[1:0] == 2'b01);

  always_comb begin
    word_o = NOP_WORD;
    err_o  = 1'b0;
    unique case (fmt_i)
      FMT_I: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i,
                  rd_i, op_i};
        // shift-immediates carry funct7 in the top bits
        if (is_shift)
          word_o[31:25] = {1'b0, funct7b5_i, 5'b0};
        err_o = !sext_ok(imm_i, 11);
      end
      FMT_S: begin
        word_o = {imm_i[11:5], rs2_i, rs1_i,
                  funct3_i, imm_i[4:0], op_i};
        err_o = !sext_ok(imm_i, 11);
      end
      FMT_B: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i,
                  rs1_i, funct3_i, imm_i[4:1],
                  imm_i[11], op_i};
        err_o = !sext_ok(imm_i, 12) || imm_i[0];
      end
      FMT_J: begin
        word_o = {imm_i[20], imm_i[10:1], imm_i[11],
                  imm_i[19:12], rd_i, op_i};
        err_o = !sext_ok(imm_i, 20) || imm_i[0];
      end
      FMT_U: begin
        word_o = {imm_i[31:12], rd_i, op_i};
        err_o  = |imm_i[11:0];
      end
      FMT_R: begin
        word_o = {1'b0, funct7b5_i, 5'b0, rs2_i,
                  rs1_i, funct3_i, rd_i, op_i};
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_program_loader.sv
// rv32i_program_loader: encodes field requests and writes them to IMEM.
// Define LOADER_VERIFY_EN to read back and compare each word after writing.
module rv32i_program_loader
  import rv32i_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  rv32i_program_loader_if.slave req,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  input  logic [31:0] im_rdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  count,
  output logic        err
);

  ld_state_e   state_q;
  logic        we_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
  logic        last_q;
  logic        err_q;
  logic [7:0]  count_q;
  logic [7:0]  count_d;
  logic [31:0] addr_q;
  logic [31:0] addr_d;
  logic [31:0] wdata_q;
  logic [31:0] enc_word;
  logic        enc_err;
  logic        sess_end;

  rv32i_instr_encoder u_enc (
    .fmt_i      (req.fmt),
    .op_i       (req.op),
    .funct3_i   (req.funct3),
    .funct7b5_i (req.funct7b5),
    .rd_i       (req.rd),
    .rs1_i      (req.rs1),
    .rs2_i      (req.rs2),
    .imm_i      (req.imm),
    .word_o     (enc_word),
    .err_o      (enc_err)
  );

  assign count_d = count_q + 8'd1;
  assign addr_d  = addr_q + 32'd4;

`ifdef LOADER_VERIFY_EN
  // checked in VERIFY, after count has already advanced
  assign sess_end = last_q
                 || (count_q == 8'(DEPTH));
`else
  assign sess_end = last_q
                 || (count_q == 8'(DEPTH - 1));
  logic unused_rdata;
  assign unused_rdata = ^im_rdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= 8'd0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'h0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_ACCEPT;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            count_q <= 8'd0;
            err_q   <= 1'b0;
            addr_q  <= BASE_ADDR;
          end
        end
        ST_ACCEPT: begin
          if (req.req_valid) begin
            state_q <= ST_WRITE;
            ready_q <= 1'b0;
            we_q    <= 1'b1;
            wdata_q <= enc_word;
            last_q  <= req.req_last;
            err_q   <= err_q | enc_err;
          end
        end
        ST_WRITE: begin
          we_q    <= 1'b0;
          count_q <= count_d;
`ifdef LOADER_VERIFY_EN
          state_q <= ST_VERIFY;
`else
          if (sess_end) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_ACCEPT;
            ready_q <= 1'b1;
            addr_q  <= addr_d;
          end
`endif
        end
`ifdef LOADER_VERIFY_EN
        ST_VERIFY: begin
          if (im_rdata != wdata_q)
            err_q <= 1'b1;
          if (sess_end) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_ACCEPT;
            ready_q <= 1'b1;
            addr_q  <= addr_d;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req.req_ready = ready_q;
  assign im_we         = we_q;
  assign im_addr       = addr_q;
  assign im_wdata      = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign count         = count_q;
  assign err           = err_q;

endmodule

// File: tb/tb_rv32i_program_loader.sv
// tb_rv32i_program_loader: directed and randomized sessions checked
// against an arithmetic encoding model and a memory write log.
module tb_rv32i_program_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int DEPTH = 8;
`ifdef LOADER_VERIFY_EN
  localparam int CAD = 3;
`else
  localparam int CAD = 2;
`endif

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        corrupt = 1'b0;
  logic        im_we, busy, done, err;
  logic [31:0] im_addr, im_wdata, im_rdata;
  logic [7:0]  count;
  logic [31:0] mem [0:255];
  wr_t         wr_q[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  rv32i_program_loader_if bus();

  rv32i_program_loader #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .req      (bus),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .im_rdata (im_rdata),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .err      (err)
  );

  always #5 clk = ~clk;

  assign im_rdata = mem[im_addr[9:2]] ^ {31'b0, corrupt};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (im_we === 1'b1) begin
      mem[im_addr[9:2]] <= im_wdata;
      wr_q.push_back('{im_addr, im_wdata, cyc});
    end
  end

  // Reference encoding built from shifted, masked fields.
  function automatic logic [31:0] ref_word(input req_t r);
    logic [31:0] i, w, op, rd, f3, r1, r2, f7;
    i  = r.imm;
    op = 32'(r.op);
    rd = 32'(r.rd) << 7;
    f3 = 32'(r.f3) << 12;
    r1 = 32'(r.rs1) << 15;
    r2 = 32'(r.rs2) << 20;
    f7 = 32'(r.f7) << 30;
    case (r.fmt)
      3'd0: begin
        w = ((i & 32'hFFF) << 20) | r1 | f3 | rd | op;
        if (r.op == 7'h13 && r.f3[1:0] == 2'b01)
          w = (w & 32'h01FF_FFFF) | f7;
      end
      3'd1: w = (((i >> 5) & 32'h7F) << 25) | r2 | r1 | f3
              | ((i & 32'h1F) << 7) | op;
      3'd2: w = (((i >> 12) & 32'h1) << 31)
              | (((i >> 5) & 32'h3F) << 25) | r2 | r1 | f3
              | (((i >> 1) & 32'hF) << 8)
              | (((i >> 11) & 32'h1) << 7) | op;
      3'd3: w = (((i >> 20) & 32'h1) << 31)
              | (((i >> 1) & 32'h3FF) << 21)
              | (((i >> 11) & 32'h1) << 20)
              | (((i >> 12) & 32'hFF) << 12) | rd | op;
      3'd4: w = (i & 32'hFFFF_F000) | rd | op;
      3'd5: w = f7 | r2 | r1 | f3 | rd | op;
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  function automatic bit ref_err(input req_t r);
    int s;
    s = $signed(r.imm);
    case (r.fmt)
      3'd0, 3'd1: return s < -2048 || s > 2047;
      3'd2: return s < -4096 || s > 4095 || r.imm[0];
      3'd3: return s < -1048576 || s > 1048575 || r.imm[0];
      3'd4: return (r.imm % 4096) != 0;
      3'd5: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic req_t rand_req();
    req_t r;
    logic signed [11:0] s12;
    logic signed [12:0] s13;
    r.fmt = 3'($urandom_range(0, 7));
    r.op  = ($urandom_range(0, 3) == 0) ? 7'h13 : 7'($urandom);
    r.f3  = 3'($urandom);
    r.f7  = 1'($urandom);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    s12   = 12'($urandom);
    s13   = 13'($urandom);
    case ($urandom_range(0, 3))
      0: r.imm = $urandom;
      1: r.imm = 32'(s12);
      2: r.imm = 32'(s13) & 32'hFFFF_FFFE;
      default: r.imm = $urandom & 32'hFFFF_F000;
    endcase
    return r;
  endfunction

  task automatic send(input req_t r, input bit last,
                      output bit ok);
    int n;
    n = 0;
    bus.fmt = r.fmt; bus.op = r.op; bus.funct3 = r.f3;
    bus.funct7b5 = r.f7; bus.rd = r.rd;
    bus.rs1 = r.rs1; bus.rs2 = r.rs2; bus.imm = r.imm;
    bus.req_last = last;
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.req_ready === 1'b1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_last = 1'b0;
  endtask

  task automatic run_session(input req_t rs[$], input bit gaps,
                             output bit ok);
    bit o;
    int n;
    ok = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < rs.size(); k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send(rs[k], k == rs.size() - 1, o);
      ok &= o;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 50);
    ok &= (done === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (im_we !== 1'b0) begin fails++;
      $display("FAIL reset_im_we got %b exp 0", im_we); end
    tests++; if (bus.req_ready !== 1'b0) begin fails++;
      $display("FAIL reset_ready got %b exp 0", bus.req_ready); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++;
      $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end
    tests++; if (count !== 8'd0 || err !== 1'b0) begin fails++;
      $display("FAIL reset_count_err got %0d/%b exp 0/0", count, err); end
    tests++; if (im_addr !== BASE || im_wdata !== 32'h0) begin fails++;
      $display("FAIL reset_addr_data got %h/%h exp %h/0",
               im_addr, im_wdata, BASE); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    req_t rs[$];
    logic [31:0] exp[4];
    bit ok;
    int b;
    exp = '{32'h00500093, 32'h00202423,
            32'h402081B3, 32'h008000EF};
    b = wr_q.size();
    rs = '{};
    rs.push_back('{3'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5});
    rs.push_back('{3'd1, 7'h23, 3'd2, 1'b0, 5'd0, 5'd0, 5'd2, 32'd8});
    rs.push_back('{3'd5, 7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0});
    rs.push_back('{3'd3, 7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8});
    run_session(rs, 1'b0, ok);
    tests++; if (!ok) begin fails++;
      $display("FAIL dir_handshake got timeout exp done"); end
    tests++; if (count !== 8'd4 || busy !== 1'b0) begin fails++;
      $display("FAIL dir_count_busy got %0d/%b exp 4/0", count, busy); end
    tests++; if (err !== 1'b0) begin fails++;
      $display("FAIL dir_err got %b exp 0", err); end
    tests++; if (wr_q.size() != b + 4) begin fails++;
      $display("FAIL dir_nwrites got %0d exp 4", wr_q.size() - b); end
    for (int k = 0; k < 4 && b + k < wr_q.size(); k++) begin
      tests++;
      if (wr_q[b+k].data !== exp[k]
          || wr_q[b+k].addr !== BASE + 32'(4*k)) begin
        fails++;
        $display("FAIL dir_word%0d got %h@%h exp %h@%h", k,
                 wr_q[b+k].data, wr_q[b+k].addr, exp[k], BASE + 32'(4*k));
      end
    end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++;
      $display("FAIL dir_done_pulse got %b exp 0", done); end
    // branch back by 4
    b = wr_q.size();
    rs = '{};
    rs.push_back('{3'd2, 7'h63, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC});
    run_session(rs, 1'b0, ok);
    tests++;
    if (!ok || err !== 1'b0 || wr_q.size() != b + 1
        || wr_q[b].data !== 32'hFE000EE3) begin
      fails++;
      $display("FAIL dir_branch got ok=%b err=%b n=%0d exp 0xFE000EE3 err 0",
               ok, err, wr_q.size() - b);
    end
    // odd jump offset
    b = wr_q.size();
    rs = '{};
    rs.push_back('{3'd3, 7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3});
    run_session(rs, 1'b0, ok);
    tests++; if (!ok || err !== 1'b1) begin fails++;
      $display("FAIL dir_jal_odd got ok=%b err=%b exp err 1", ok, err); end
    tests++;
    if (wr_q.size() != b + 1 || wr_q[b].data !== ref_word(rs[0])) begin
      fails++;
      $display("FAIL dir_jal_odd_word got n=%0d exp %h",
               wr_q.size() - b, ref_word(rs[0]));
    end
  endtask

  task automatic test_random();
    req_t rs[$];
    bit ok, exp_err;
    int b, len;
    for (int s = 0; s < 12; s++) begin
      rs = '{};
      exp_err = 1'b0;
      len = $urandom_range(1, DEPTH - 1);
      for (int k = 0; k < len; k++) begin
        rs.push_back(rand_req());
        exp_err |= ref_err(rs[k]);
      end
      b = wr_q.size();
      run_session(rs, 1'b1, ok);
      tests++;
      if (!ok || count !== 8'(len) || busy !== 1'b0) begin
        fails++;
        $display("FAIL rnd%0d_session got ok=%b count=%0d busy=%b exp count %0d",
                 s, ok, count, busy, len);
      end
      tests++; if (err !== exp_err) begin fails++;
        $display("FAIL rnd%0d_err got %b exp %b", s, err, exp_err); end
      tests++; if (wr_q.size() != b + len) begin fails++;
        $display("FAIL rnd%0d_nwrites got %0d exp %0d", s, wr_q.size() - b, len); end
      for (int k = 0; k < len && b + k < wr_q.size(); k++) begin
        tests++;
        if (wr_q[b+k].data !== ref_word(rs[k])
            || wr_q[b+k].addr !== BASE + 32'(4*k)) begin
          fails++;
          $display("FAIL rnd%0d_word%0d got %h@%h exp %h@%h", s, k,
                   wr_q[b+k].data, wr_q[b+k].addr,
                   ref_word(rs[k]), BASE + 32'(4*k));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    req_t r;
    int b, n;
    bit hit;
    r = rand_req();
    r.fmt = 3'd5;
    b = wr_q.size();
    bus.fmt = r.fmt; bus.op = r.op; bus.funct3 = r.f3;
    bus.funct7b5 = r.f7; bus.rd = r.rd;
    bus.rs1 = r.rs1; bus.rs2 = r.rs2; bus.imm = r.imm;
    bus.req_last = 1'b0;
    bus.req_valid = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (wr_q.size() != b || busy !== 1'b0) begin fails++;
      $display("FAIL b2b_idle_consume got n=%0d busy=%b exp 0/0",
               wr_q.size() - b, busy); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 100);
    tests++; if (done !== 1'b1) begin fails++;
      $display("FAIL b2b_done got timeout exp done"); end
    tests++; if (count !== 8'(DEPTH) || err !== 1'b0) begin fails++;
      $display("FAIL b2b_full got count=%0d err=%b exp %0d/0",
               count, err, DEPTH); end
    tests++; if (wr_q.size() != b + DEPTH) begin fails++;
      $display("FAIL b2b_nwrites got %0d exp %0d", wr_q.size() - b, DEPTH); end
    for (int k = 0; k < DEPTH && b + k < wr_q.size(); k++) begin
      tests++;
      if (wr_q[b+k].addr !== BASE + 32'(4*k)
          || wr_q[b+k].data !== ref_word(r)
          || (k > 0 && wr_q[b+k].cyc - wr_q[b+k-1].cyc != CAD)) begin
        fails++;
        $display("FAIL b2b_word%0d got %h@%h exp %h@%h cadence %0d",
                 k, wr_q[b+k].data, wr_q[b+k].addr, ref_word(r),
                 BASE + 32'(4*k), CAD);
      end
    end
    repeat (6) @(negedge clk);
    hit = 1'b0;
    for (int k = b; k < wr_q.size(); k++)
      if (wr_q[k].addr == BASE + 32'(4*DEPTH)) hit = 1'b1;
    tests++; if (hit || wr_q.size() != b + DEPTH) begin fails++;
      $display("FAIL b2b_overrun got n=%0d hit=%b exp %0d/0",
               wr_q.size() - b, hit, DEPTH); end
    bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req_t r;
    bit ok;
    int b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r = rand_req();
    r.fmt = 3'd7;
    send(r, 1'b0, ok);
    r.fmt = 3'd5;
    send(r, 1'b0, ok);
    b = wr_q.size();
    tests++; if (!ok || im_we !== 1'b1 || count !== 8'd1 || err !== 1'b1) begin
      fails++;
      $display("FAIL mid_prewrite got we=%b count=%0d err=%b exp 1/1/1",
               im_we, count, err); end
    reset = 1'b1;
    #1;
    tests++; if (im_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_ctl got we=%b busy=%b done=%b exp 000",
               im_we, busy, done); end
    tests++; if (count !== 8'd0 || err !== 1'b0 || bus.req_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_state got count=%0d err=%b rdy=%b exp 0/0/0",
               count, err, bus.req_ready); end
    tests++; if (im_addr !== BASE || im_wdata !== 32'h0) begin fails++;
      $display("FAIL mid_reset_bus got %h/%h exp %h/0",
               im_addr, im_wdata, BASE); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++; if (wr_q.size() != b) begin fails++;
      $display("FAIL mid_reset_write got %0d writes exp 0", wr_q.size() - b); end
  endtask

  task automatic test_verify();
    req_t rs[$];
    bit ok, exp_bad;
`ifdef LOADER_VERIFY_EN
    exp_bad = 1'b1;
`else
    exp_bad = 1'b0;
`endif
    rs = '{};
    rs.push_back('{3'd0, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5});
    corrupt = 1'b1;
    run_session(rs, 1'b0, ok);
    corrupt = 1'b0;
    tests++; if (!ok || err !== exp_bad) begin fails++;
      $display("FAIL verify_corrupt got ok=%b err=%b exp err %b",
               ok, err, exp_bad); end
    tests++; if (wr_q[wr_q.size()-1].data !== 32'h00500093) begin fails++;
      $display("FAIL verify_word got %h exp 00500093",
               wr_q[wr_q.size()-1].data); end
    run_session(rs, 1'b0, ok);
    tests++; if (!ok || err !== 1'b0) begin fails++;
      $display("FAIL verify_clean got ok=%b err=%b exp err 0", ok, err); end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_last  = 1'b0;
    bus.fmt = 3'd0; bus.op = 7'd0; bus.funct3 = 3'd0;
    bus.funct7b5 = 1'b0; bus.rd = 5'd0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.imm = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_verify();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
